// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: state encoding,
// start/sign encodings and the HI/LO layout of the packed result.
package div_unit_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DZERO = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

    localparam logic DIV_START    = 1'b1;
    localparam logic DIV_STOP     = 1'b0;
    localparam logic DIV_SIGNED   = 1'b1;
    localparam logic DIV_UNSIGNED = 1'b0;

    // result = {remainder -> HI, quotient -> LO}
    localparam int LO_LSB = 0;
    localparam int LO_MSB = DIV_W - 1;
    localparam int HI_LSB = DIV_W;
    localparam int HI_MSB = 2 * DIV_W - 1;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle,
// producing {remainder, quotient} for HI/LO and a busy stall indication.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e         state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH:0]   work, work_step, shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   dvs_mag;
    logic               neg_q, neg_r;
    logic               a_neg, b_neg, div_zero, go;

    // Two's-complement negate when requested; 0x8000_0000 maps to itself,
    // which reads correctly as the unsigned magnitude 2^31.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign a_neg    = (signed_div_i == DIV_SIGNED) && opdata1_i[WIDTH-1];
    assign b_neg    = (signed_div_i == DIV_SIGNED) && opdata2_i[WIDTH-1];
    assign div_zero = (opdata2_i == '0);
    assign go       = (start_i == DIV_START) && !annul_i;

    always_comb begin
        state_n   = state;
        shifted   = work << 1;
        diff      = shifted[2*WIDTH:WIDTH] - {1'b0, dvs_mag};
        work_step = diff[WIDTH] ? shifted
                                : {diff, shifted[WIDTH-1:1], 1'b1};
        case (state)
            ST_IDLE:  if (go) state_n = div_zero ? ST_DZERO : ST_BUSY;
            ST_DZERO: state_n = annul_i ? ST_IDLE : ST_DONE;
            ST_BUSY: begin
                if (annul_i)                 state_n = ST_IDLE;
                else if (cnt == CW'(WIDTH))  state_n = ST_DONE;
            end
            ST_DONE:  if (start_i == DIV_STOP) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            work     <= '0;
            dvs_mag  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state  <= state_n;
            busy_o <= (state_n == ST_BUSY) || (state_n == ST_DZERO);
            case (state)
                ST_IDLE: if (go) begin
                    cnt     <= '0;
                    // Divide-by-zero keeps the raw dividend to hand back as HI.
                    work    <= {{(WIDTH+1){1'b0}},
                                div_zero ? opdata1_i : cond_neg(opdata1_i, a_neg)};
                    dvs_mag <= cond_neg(opdata2_i, b_neg);
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                end
                ST_BUSY: if (!annul_i) begin
                    if (cnt == CW'(WIDTH)) begin
                        result_o <= {cond_neg(work[2*WIDTH-1:WIDTH], neg_r),
                                     cond_neg(work[WIDTH-1:0], neg_q)};
                        ready_o  <= 1'b1;
                    end else begin
                        work <= work_step;
                        cnt  <= cnt + 1'b1;
                    end
                end
                ST_DZERO: if (!annul_i) begin
                    result_o <= {work[WIDTH-1:0], {WIDTH{1'b1}}};
                    ready_o  <= 1'b1;
                end
                ST_DONE: if (start_i == DIV_STOP) begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
